// File: rtl/tpg_timing_ctrl.sv
// Run controller and timing-configuration scheduler for the test-pattern generator.
// Latency: IDLE commit -> active set 1 cycle; start -> tpg_en 1 cycle; sof -> update/stop 1 cycle.
// Backpressure: none; shadow writes are dropped while busy, rejected commits pulse commit_err.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   cfg_we/addr/wdata shadow bank write port (0-4 horizontal, 5-9 vertical, 10 frame_limit)
//   commit/start/stop single-cycle control pulses from the register bus
//   sof               start-of-frame pulse returned by the TPG
//   tHS_START..tV_END active timing set driven to the TPG
//   tpg_en, active_valid, busy, commit_done, commit_err, frame_cnt  status outputs
module tpg_timing_ctrl #(
  parameter int H_BITS  = 12,
  parameter int V_BITS  = 12,
  parameter int FC_BITS = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [3:0]         cfg_addr,
  input  logic [15:0]        cfg_wdata,
  input  logic               commit,
  input  logic               start,
  input  logic               stop,
  input  logic               sof,
  output logic [H_BITS-1:0]  tHS_START,
  output logic [H_BITS-1:0]  tHS_END,
  output logic [H_BITS-1:0]  tHACT_START,
  output logic [H_BITS-1:0]  tHACT_END,
  output logic [H_BITS-1:0]  tH_END,
  output logic [V_BITS-1:0]  tVS_START,
  output logic [V_BITS-1:0]  tVS_END,
  output logic [V_BITS-1:0]  tVACT_START,
  output logic [V_BITS-1:0]  tVACT_END,
  output logic [V_BITS-1:0]  tV_END,
  output logic               tpg_en,
  output logic               active_valid,
  output logic               busy,
  output logic               commit_done,
  output logic               commit_err,
  output logic [FC_BITS-1:0] frame_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RUN       = 2'd1,
    ST_PEND      = 2'd2,
    ST_STOP_PEND = 2'd3
  } state_t;

  // Index order inside each bank: 0 S_START, 1 S_END, 2 ACT_START, 3 ACT_END, 4 END
  logic [H_BITS-1:0]  r_sh_h  [5];
  logic [V_BITS-1:0]  r_sh_v  [5];
  logic [FC_BITS-1:0] r_sh_fl;
  logic [H_BITS-1:0]  r_act_h [5];
  logic [V_BITS-1:0]  r_act_v [5];
  logic [FC_BITS-1:0] r_act_fl;

  state_t             r_state;
  logic               r_tpg_en;
  logic               r_active_valid;
  logic               r_busy;
  logic               r_commit_done;
  logic               r_commit_err;
  logic [FC_BITS-1:0] r_frame_cnt;

  logic w_h_ok;
  logic w_v_ok;
  logic w_cfg_ok;
  logic w_limit_hit;

  // Validity is judged on the shadow bank as it stands in the commit cycle.
  assign w_h_ok = (r_sh_h[0] < r_sh_h[1]) && (r_sh_h[1] <= r_sh_h[4]) &&
                  (r_sh_h[2] < r_sh_h[3]) && (r_sh_h[3] <= r_sh_h[4]);
  assign w_v_ok = (r_sh_v[0] < r_sh_v[1]) && (r_sh_v[1] <= r_sh_v[4]) &&
                  (r_sh_v[2] < r_sh_v[3]) && (r_sh_v[3] <= r_sh_v[4]);
  assign w_cfg_ok = w_h_ok && w_v_ok;

  // A zero limit means free run.
  assign w_limit_hit = (r_act_fl != '0) && (r_frame_cnt == r_act_fl);

  // Shadow bank; frozen while a transfer or stop is pending so the pending
  // commit always copies exactly what was validated.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 5; i++) begin
        r_sh_h[i] <= '0;
        r_sh_v[i] <= '0;
      end
      r_sh_fl <= '0;
    end else if (cfg_we && !r_busy) begin
      case (cfg_addr)
        4'd0:  r_sh_h[0] <= cfg_wdata[H_BITS-1:0];
        4'd1:  r_sh_h[1] <= cfg_wdata[H_BITS-1:0];
        4'd2:  r_sh_h[2] <= cfg_wdata[H_BITS-1:0];
        4'd3:  r_sh_h[3] <= cfg_wdata[H_BITS-1:0];
        4'd4:  r_sh_h[4] <= cfg_wdata[H_BITS-1:0];
        4'd5:  r_sh_v[0] <= cfg_wdata[V_BITS-1:0];
        4'd6:  r_sh_v[1] <= cfg_wdata[V_BITS-1:0];
        4'd7:  r_sh_v[2] <= cfg_wdata[V_BITS-1:0];
        4'd8:  r_sh_v[3] <= cfg_wdata[V_BITS-1:0];
        4'd9:  r_sh_v[4] <= cfg_wdata[V_BITS-1:0];
        4'd10: r_sh_fl   <= cfg_wdata[FC_BITS-1:0];
        default: ;
      endcase
    end
  end

  // Run-control FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_tpg_en       <= 1'b0;
      r_active_valid <= 1'b0;
      r_busy         <= 1'b0;
      r_commit_done  <= 1'b0;
      r_commit_err   <= 1'b0;
      r_frame_cnt    <= '0;
      for (int i = 0; i < 5; i++) begin
        r_act_h[i] <= '0;
        r_act_v[i] <= '0;
      end
      r_act_fl <= '0;
    end else begin
      r_commit_done <= 1'b0;
      r_commit_err  <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          // commit outranks start; stop has nothing to act on here
          if (commit) begin
            if (w_cfg_ok) begin
              r_act_h        <= r_sh_h;
              r_act_v        <= r_sh_v;
              r_act_fl       <= r_sh_fl;
              r_commit_done  <= 1'b1;
              r_active_valid <= 1'b1;
            end else begin
              r_commit_err <= 1'b1;
            end
          end else if (start && r_active_valid) begin
            r_state     <= ST_RUN;
            r_tpg_en    <= 1'b1;
            r_frame_cnt <= '0;
          end
        end

        ST_RUN: begin
          if (sof && w_limit_hit) begin
            // Limit reached: the run ends here, so a commit has nowhere to go.
            r_state  <= ST_IDLE;
            r_tpg_en <= 1'b0;
            if (commit) r_commit_err <= 1'b1;
          end else begin
            // A sof in the same cycle as stop/commit still counts as a frame;
            // a commit accepted now waits for the next sof.
            if (sof) r_frame_cnt <= r_frame_cnt + 1'b1;
            if (stop) begin
              r_state <= ST_STOP_PEND;
              r_busy  <= 1'b1;
              if (commit) r_commit_err <= 1'b1;
            end else if (commit) begin
              if (w_cfg_ok) begin
                r_state <= ST_PEND;
                r_busy  <= 1'b1;
              end else begin
                r_commit_err <= 1'b1;
              end
            end
          end
        end

        ST_PEND: begin
          if (stop) begin
            // Pending transfer is discarded.
            r_state      <= ST_STOP_PEND;
            r_commit_err <= 1'b1;
            if (sof) r_frame_cnt <= r_frame_cnt + 1'b1;
          end else if (sof) begin
            // Shadow is frozen while busy, so a commit arriving with this sof
            // asks for exactly the set being applied; it is absorbed silently
            // to keep done and err mutually exclusive.
            r_act_h       <= r_sh_h;
            r_act_v       <= r_sh_v;
            r_act_fl      <= r_sh_fl;
            r_commit_done <= 1'b1;
            r_frame_cnt   <= r_frame_cnt + 1'b1;
            r_state       <= ST_RUN;
            r_busy        <= 1'b0;
          end else if (commit) begin
            r_commit_err <= 1'b1;
          end
        end

        ST_STOP_PEND: begin
          if (commit) r_commit_err <= 1'b1;
          if (sof) begin
            r_state  <= ST_IDLE;
            r_tpg_en <= 1'b0;
            r_busy   <= 1'b0;
          end
        end

        default: begin
          r_state  <= ST_IDLE;
          r_tpg_en <= 1'b0;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

  assign tHS_START    = r_act_h[0];
  assign tHS_END      = r_act_h[1];
  assign tHACT_START  = r_act_h[2];
  assign tHACT_END    = r_act_h[3];
  assign tH_END       = r_act_h[4];
  assign tVS_START    = r_act_v[0];
  assign tVS_END      = r_act_v[1];
  assign tVACT_START  = r_act_v[2];
  assign tVACT_END    = r_act_v[3];
  assign tV_END       = r_act_v[4];
  assign tpg_en       = r_tpg_en;
  assign active_valid = r_active_valid;
  assign busy         = r_busy;
  assign commit_done  = r_commit_done;
  assign commit_err   = r_commit_err;
  assign frame_cnt    = r_frame_cnt;

endmodule

// File: tb/tb_tpg_timing_ctrl.sv
// Directed self-checking bench for tpg_timing_ctrl.
// Latency: n/a (drives at posedge+1, samples at posedge+1 of the following edge).
// Backpressure: n/a.
module tb_tpg_timing_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we;
  logic [3:0]  cfg_addr;
  logic [15:0] cfg_wdata;
  logic        commit, start, stop, sof;
  logic [11:0] tHS_START, tHS_END, tHACT_START, tHACT_END, tH_END;
  logic [11:0] tVS_START, tVS_END, tVACT_START, tVACT_END, tV_END;
  logic        tpg_en, active_valid, busy, commit_done, commit_err;
  logic [15:0] frame_cnt;

  int n_pass = 0;
  int n_chk  = 0;

  tpg_timing_ctrl #(.H_BITS(12), .V_BITS(12), .FC_BITS(16)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .commit(commit), .start(start), .stop(stop), .sof(sof),
    .tHS_START(tHS_START), .tHS_END(tHS_END), .tHACT_START(tHACT_START),
    .tHACT_END(tHACT_END), .tH_END(tH_END),
    .tVS_START(tVS_START), .tVS_END(tVS_END), .tVACT_START(tVACT_START),
    .tVACT_END(tVACT_END), .tV_END(tV_END),
    .tpg_en(tpg_en), .active_valid(active_valid), .busy(busy),
    .commit_done(commit_done), .commit_err(commit_err), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic do_commit();
    commit = 1'b1; tick(); commit = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic do_sof();
    sof = 1'b1; tick(); sof = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    n_chk++; if ({tpg_en, active_valid, busy, commit_done, commit_err} !== 5'b0)
      $display("FAIL reset_flags got %b want 00000", {tpg_en, active_valid, busy, commit_done, commit_err});
      else n_pass++;
    n_chk++; if (frame_cnt !== 16'd0) $display("FAIL reset_frame_cnt got %0d want 0", frame_cnt); else n_pass++;
    n_chk++; if ({tH_END, tV_END} !== 24'd0) $display("FAIL reset_timing got %0d/%0d want 0/0", tH_END, tV_END); else n_pass++;
    do_start();
    n_chk++; if (tpg_en !== 1'b0) $display("FAIL start_uncommitted got %b want 0", tpg_en); else n_pass++;
    tick();
    n_chk++; if (tpg_en !== 1'b0) $display("FAIL start_uncommitted_hold got %b want 0", tpg_en); else n_pass++;
  endtask

  task automatic test_idle_commit();
    wr(0, 656); wr(1, 752); wr(2, 0);   wr(3, 640); wr(4, 799);
    wr(5, 490); wr(6, 492); wr(7, 0);   wr(8, 480); wr(9, 524);
    n_chk++; if (tH_END !== 12'd0) $display("FAIL shadow_not_active got %0d want 0", tH_END); else n_pass++;
    do_commit();
    n_chk++; if ({commit_done, active_valid, commit_err} !== 3'b110)
      $display("FAIL idle_commit_flags got %b want 110", {commit_done, active_valid, commit_err}); else n_pass++;
    n_chk++; if ({tHS_START, tH_END, tVACT_END, tV_END} !== {12'd656, 12'd799, 12'd480, 12'd524})
      $display("FAIL idle_commit_values got %0d %0d %0d %0d want 656 799 480 524", tHS_START, tH_END, tVACT_END, tV_END);
      else n_pass++;
    tick();
    n_chk++; if (commit_done !== 1'b0) $display("FAIL done_one_cycle got %b want 0", commit_done); else n_pass++;
    do_start();
    n_chk++; if ({tpg_en, busy} !== 2'b10 || frame_cnt !== 16'd0)
      $display("FAIL start_run got en/busy %b cnt %0d want 10 cnt 0", {tpg_en, busy}, frame_cnt); else n_pass++;
  endtask

  task automatic test_run_commit();
    wr(4, 800);
    do_commit();
    n_chk++; if ({busy, commit_done} !== 2'b10 || tH_END !== 12'd799)
      $display("FAIL pend_enter got busy/done %b hend %0d want 10 799", {busy, commit_done}, tH_END); else n_pass++;
    do_commit();
    n_chk++; if ({commit_err, commit_done} !== 2'b10)
      $display("FAIL pend_second_commit got err/done %b want 10", {commit_err, commit_done}); else n_pass++;
    wr(4, 900);  // dropped: shadow is locked while busy
    n_chk++; if (commit_err !== 1'b0 || tH_END !== 12'd799)
      $display("FAIL pend_hold got err %b hend %0d want 0 799", commit_err, tH_END); else n_pass++;
    do_sof();
    n_chk++; if ({commit_done, busy, tpg_en} !== 3'b101 || tH_END !== 12'd800 || frame_cnt !== 16'd1)
      $display("FAIL pend_apply got done/busy/en %b hend %0d cnt %0d want 101 800 1",
               {commit_done, busy, tpg_en}, tH_END, frame_cnt); else n_pass++;
    stop = 1'b1; tick(); stop = 1'b0;
    n_chk++; if ({busy, tpg_en} !== 2'b11) $display("FAIL stop_pend got busy/en %b want 11", {busy, tpg_en}); else n_pass++;
    do_sof();
    n_chk++; if ({busy, tpg_en} !== 2'b00 || frame_cnt !== 16'd1)
      $display("FAIL stop_done got busy/en %b cnt %0d want 00 1", {busy, tpg_en}, frame_cnt); else n_pass++;
  endtask

  task automatic test_invalid_commit();
    wr(0, 16); wr(1, 16);
    do_commit();
    n_chk++; if ({commit_err, commit_done} !== 2'b10)
      $display("FAIL invalid_flags got err/done %b want 10", {commit_err, commit_done}); else n_pass++;
    n_chk++; if ({tHS_START, tHS_END} !== {12'd656, 12'd752})
      $display("FAIL invalid_unchanged got %0d %0d want 656 752", tHS_START, tHS_END); else n_pass++;
    tick();
    n_chk++; if (commit_err !== 1'b0) $display("FAIL err_one_cycle got %b want 0", commit_err); else n_pass++;
    wr(0, 656); wr(1, 752);
  endtask

  task automatic test_frame_limit();
    logic [15:0] exp_cnt [5];
    logic        exp_en  [5];
    exp_cnt = '{16'd1, 16'd2, 16'd3, 16'd3, 16'd3};
    exp_en  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    wr(10, 3);
    do_commit();
    tick();
    do_start();
    for (int i = 0; i < 5; i++) begin
      do_sof();
      n_chk++; if (frame_cnt !== exp_cnt[i] || tpg_en !== exp_en[i])
        $display("FAIL limit_sof%0d got cnt %0d en %b want cnt %0d en %b",
                 i + 1, frame_cnt, tpg_en, exp_cnt[i], exp_en[i]); else n_pass++;
      tick();
    end
  endtask

  task automatic test_stop_commit();
    wr(10, 0);
    do_commit();
    tick();
    do_start();
    stop = 1'b1; commit = 1'b1; tick(); stop = 1'b0; commit = 1'b0;
    n_chk++; if ({commit_err, commit_done, busy, tpg_en} !== 4'b1011)
      $display("FAIL stop_commit got err/done/busy/en %b want 1011", {commit_err, commit_done, busy, tpg_en}); else n_pass++;
    tick();
    n_chk++; if (tpg_en !== 1'b1) $display("FAIL stop_wait_sof got %b want 1", tpg_en); else n_pass++;
    do_sof();
    n_chk++; if ({tpg_en, busy} !== 2'b00 || frame_cnt !== 16'd0)
      $display("FAIL stop_commit_end got en/busy %b cnt %0d want 00 0", {tpg_en, busy}, frame_cnt); else n_pass++;
  endtask

  task automatic test_reset_pend();
    do_start();
    do_commit();
    n_chk++; if (busy !== 1'b1) $display("FAIL pre_reset_pend got %b want 1", busy); else n_pass++;
    rst = 1'b1; tick(); rst = 1'b0;
    n_chk++; if ({tpg_en, active_valid, busy, commit_done, commit_err} !== 5'b0 || frame_cnt !== 16'd0)
      $display("FAIL reset_pend_flags got %b cnt %0d want 00000 0",
               {tpg_en, active_valid, busy, commit_done, commit_err}, frame_cnt); else n_pass++;
    n_chk++; if ({tHS_START, tH_END, tV_END} !== 36'd0)
      $display("FAIL reset_pend_timing got %0d %0d %0d want 0 0 0", tHS_START, tH_END, tV_END); else n_pass++;
  endtask

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    commit = 1'b0; start = 1'b0; stop = 1'b0; sof = 1'b0;
    test_reset();
    test_idle_commit();
    test_run_commit();
    test_invalid_commit();
    test_frame_limit();
    test_stop_commit();
    test_reset_pend();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
